// File: rtl/multiply_lanes_pipelined.sv
// Lane-wise signed fixed-point multiplier between two input FIFOs and one output FIFO.
// Define MULT_SATURATE_EN to clamp out-of-range results and raise sticky per-lane sat_flag bits.
module multiply_lanes_pipelined #(
    parameter int WIDTH     = 32,
    parameter int LANES     = 2,
    parameter int FRAC_BITS = 10,
    parameter int STAGES    = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   inA_rd_en,
    input  logic                   inA_empty,
    input  logic [LANES*WIDTH-1:0] inA_dout,
    output logic                   inB_rd_en,
    input  logic                   inB_empty,
    input  logic [LANES*WIDTH-1:0] inB_dout,
    output logic                   out_wr_en,
    input  logic                   out_full,
    output logic [LANES*WIDTH-1:0] out_din,
    output logic [LANES-1:0]       sat_flag,
    output logic [31:0]            out_count
);

    localparam int PW = 2 * WIDTH;

    logic [STAGES-1:0]      vld_q;
    logic [STAGES-1:0]      vld_d;
    logic                   advance;
    logic                   popEn;
    logic                   lastLoad;
    logic [LANES*PW-1:0]    prodComb;
    logic [LANES*PW-1:0]    lastIn;
    logic [LANES*WIDTH-1:0] narrowComb;
    logic [LANES*WIDTH-1:0] outData_q;
    logic [31:0]            count_q;

    // The whole pipeline freezes only when the head word cannot be pushed.
    assign advance   = !(vld_q[STAGES-1] && out_full);
    assign popEn     = !inA_empty && !inB_empty && advance;
    assign inA_rd_en = popEn;
    assign inB_rd_en = popEn;
    assign out_wr_en = vld_q[STAGES-1] && !out_full;
    assign out_din   = outData_q;
    assign out_count = count_q;

    always_comb begin
        prodComb = '0;
        for (int l = 0; l < LANES; l++) begin
            prodComb[l*PW +: PW] =
                $signed({{WIDTH{inA_dout[l*WIDTH+WIDTH-1]}}, inA_dout[l*WIDTH +: WIDTH]}) *
                $signed({{WIDTH{inB_dout[l*WIDTH+WIDTH-1]}}, inB_dout[l*WIDTH +: WIDTH]});
        end
    end

    always_comb begin
        vld_d = vld_q;
        if (advance) begin
            vld_d = (vld_q << 1) | STAGES'(popEn);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Full-width products ride the early stages; only the last stage holds narrowed results.
    generate
        if (STAGES == 1) begin : gNoWide
            assign lastIn   = prodComb;
            assign lastLoad = popEn;
        end else begin : gWide
            logic [LANES*PW-1:0] wide_q [STAGES-1];

            always_ff @(posedge clock) begin
                if (!reset) begin
                    for (int k = 0; k < STAGES-1; k++) begin
                        wide_q[k] <= '0;
                    end
                end else if (advance) begin
                    if (popEn) begin
                        wide_q[0] <= prodComb;
                    end
                    for (int k = 1; k < STAGES-1; k++) begin
                        if (vld_q[k-1]) begin
                            wide_q[k] <= wide_q[k-1];
                        end
                    end
                end
            end

            assign lastIn   = wide_q[STAGES-2];
            assign lastLoad = vld_q[STAGES-2];
        end
    endgenerate

`ifdef MULT_SATURATE_EN
    logic signed [PW-1:0] qLane;
    logic [LANES-1:0]     satComb;
    logic [LANES-1:0]     satStage_q;
    logic [LANES-1:0]     satFlag_q;

    // The result fits when every bit from the narrow sign bit upward agrees.
    always_comb begin
        qLane      = '0;
        narrowComb = '0;
        satComb    = '0;
        for (int l = 0; l < LANES; l++) begin
            qLane = $signed(lastIn[l*PW +: PW]) >>> FRAC_BITS;
            if ((&qLane[PW-1:WIDTH-1]) || !(|qLane[PW-1:WIDTH-1])) begin
                narrowComb[l*WIDTH +: WIDTH] = qLane[WIDTH-1:0];
            end else begin
                satComb[l] = 1'b1;
                narrowComb[l*WIDTH +: WIDTH] = qLane[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                           : {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            satStage_q <= '0;
            satFlag_q  <= '0;
        end else begin
            if (advance && lastLoad) begin
                satStage_q <= satComb;
            end
            if (out_wr_en) begin
                satFlag_q <= satFlag_q | satStage_q;
            end
        end
    end

    assign sat_flag = satFlag_q;
`else
    logic unusedProdBits;

    always_comb begin
        narrowComb = '0;
        for (int l = 0; l < LANES; l++) begin
            narrowComb[l*WIDTH +: WIDTH] = lastIn[l*PW + FRAC_BITS +: WIDTH];
        end
    end

    assign unusedProdBits = ^lastIn;
    assign sat_flag       = '0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            outData_q <= '0;
        end else if (advance && lastLoad) begin
            outData_q <= narrowComb;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
        end else if (out_wr_en) begin
            count_q <= count_q + 32'd1;
        end
    end

endmodule
